// File: rtl/adc_serial_responder_pkg.sv
// Shared constants and FSM encoding for the 3-wire ADC link; both link ends use these
// so they agree on frame length and state numbering.
package adc_serial_responder_pkg;

  localparam int DATA_WIDTH_DEF  = 12;
  localparam int LEAD_ZEROS_DEF  = 4;
  localparam int FRAME_BITS_DEF  = LEAD_ZEROS_DEF + DATA_WIDTH_DEF;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TONE_STEP_DEF   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2
  } state_t;

endpackage

// File: rtl/adc_serial_responder_if.sv
// Serial ADC pins plus the sample valid/ready feed and status pulses of the responder.
// The responder takes the slave view; the reader/sample source takes the master view.
interface adc_serial_responder_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  adc_cs;
  logic                  adc_clk;
  logic                  adc_sd;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  frame_done;
  logic                  frame_abort;
  logic                  underrun;

  modport slave (
    input  adc_cs, adc_clk, s_data, s_valid,
    output adc_sd, s_ready, frame_done, frame_abort, underrun
  );

  modport master (
    output adc_cs, adc_clk, s_data, s_valid,
    input  adc_sd, s_ready, frame_done, frame_abort, underrun
  );
endinterface

// File: rtl/adc_serial_responder_sync_edge_detect.sv
// Synchronizer chain plus edge register for one asynchronous pin; rise/fall pulses are
// valid SYNC_STAGES+1 clk after the pin changes. Pins idle high, so reset loads ones.
module adc_serial_responder_sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/adc_serial_responder.sv
// Stands in for an ADCS7476: serves held samples MSB first on adc_sd, one bit per adc_clk fall,
// adc_sd moves 1 clk after a detected edge. ADC_RESP_TONE_EN replaces underrun repeats with a sawtooth.
module adc_serial_responder
  import adc_serial_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int LEAD_ZEROS  = LEAD_ZEROS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TONE_STEP   = TONE_STEP_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  adc_serial_responder_if.slave  bus
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS);

  state_t                  r_state, w_state_nxt;
  logic [FRAME_BITS-1:0]   r_shift, w_shift_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    r_sd, w_sd_nxt;
  logic [DATA_WIDTH-1:0]   r_hold, w_hold_nxt;
  logic                    r_full, w_full_nxt;
  logic [DATA_WIDTH-1:0]   r_last, w_last_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_abort, w_abort_nxt;
  logic                    r_underrun, w_underrun_nxt;
  logic                    w_cs_rise, w_cs_fall, w_clk_fall;
  // reader samples on the rising edge, so only falls matter here
  logic                    w_clk_rise_unused;
  logic                    w_load;
  logic [DATA_WIDTH-1:0]   w_fallback, w_sample;
  logic [FRAME_BITS-1:0]   w_frame;

  adc_serial_responder_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(reset), .i_din(bus.adc_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  adc_serial_responder_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(clk), .rst(reset), .i_din(bus.adc_clk), .o_rise(w_clk_rise_unused), .o_fall(w_clk_fall)
  );

`ifdef ADC_RESP_TONE_EN
  logic [DATA_WIDTH-1:0] r_tone, w_tone_nxt;
  assign w_fallback = r_tone;
`else
  assign w_fallback = r_last;
`endif

  assign w_load   = bus.s_valid && !r_full;
  assign w_sample = r_full ? r_hold : w_fallback;
  assign w_frame  = {{LEAD_ZEROS{1'b0}}, w_sample};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sd       <= 1'b0;
      r_hold     <= '0;
      r_full     <= 1'b0;
      r_last     <= '0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_underrun <= 1'b0;
`ifdef ADC_RESP_TONE_EN
      r_tone     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sd       <= w_sd_nxt;
      r_hold     <= w_hold_nxt;
      r_full     <= w_full_nxt;
      r_last     <= w_last_nxt;
      r_done     <= w_done_nxt;
      r_abort    <= w_abort_nxt;
      r_underrun <= w_underrun_nxt;
`ifdef ADC_RESP_TONE_EN
      r_tone     <= w_tone_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_sd_nxt       = r_sd;
    w_hold_nxt     = r_hold;
    w_full_nxt     = r_full;
    w_last_nxt     = r_last;
    w_done_nxt     = 1'b0;
    w_abort_nxt    = 1'b0;
    w_underrun_nxt = 1'b0;
`ifdef ADC_RESP_TONE_EN
    w_tone_nxt     = r_tone;
`endif

    case (r_state)
      ST_IDLE: begin
        w_sd_nxt = 1'b0;
        // a coincident adc_clk fall is deliberately ignored so bit 1 is not skipped
        if (w_cs_fall) begin
          w_state_nxt    = ST_SHIFT;
          w_shift_nxt    = w_frame;
          w_sd_nxt       = w_frame[FRAME_BITS-1];
          w_cnt_nxt      = CNT_W'(1);
          w_last_nxt     = w_sample;
          w_underrun_nxt = !r_full;
          w_full_nxt     = 1'b0;
`ifdef ADC_RESP_TONE_EN
          if (!r_full) w_tone_nxt = r_tone + DATA_WIDTH'(TONE_STEP);
`endif
        end
      end
      ST_SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
          w_sd_nxt    = 1'b0;
        end else if (w_clk_fall) begin
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = ST_TAIL;
            w_sd_nxt    = 1'b0;
          end else begin
            w_shift_nxt = {r_shift[FRAME_BITS-2:0], 1'b0};
            w_sd_nxt    = r_shift[FRAME_BITS-2];
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_TAIL: begin
        w_sd_nxt = 1'b0;
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sd_nxt    = 1'b0;
      end
    endcase

    // load only happens while empty, so it never collides with a frame consuming the holding reg
    if (w_load) begin
      w_hold_nxt = bus.s_data;
      w_full_nxt = 1'b1;
    end
  end

  assign bus.adc_sd      = r_sd;
  assign bus.s_ready     = !r_full;
  assign bus.frame_done  = r_done;
  assign bus.frame_abort = r_abort;
  assign bus.underrun    = r_underrun;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench: acts as the ADC reader and sample source, checks recovered words and status pulses.
`timescale 1ns/1ps
module tb_adc_serial_responder;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done = 0, n_abort = 0, n_un = 0;

  adc_serial_responder_if #(.DATA_WIDTH(12)) bus ();

  adc_serial_responder dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #25 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_done)  n_done++;
    if (bus.frame_abort) n_abort++;
    if (bus.underrun)    n_un++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        load;
    logic [11:0] data;
    int          falls;
    logic [31:0] exp_word;
    int          exp_un;
    int          exp_done;
    int          exp_abort;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [11:0] d);
    int k;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    k = 0;
    while (!bus.s_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.s_ready) check("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic start_frame(input int half);
    bus.adc_cs = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  task automatic shift_bits(input int n, input int half, output logic [31:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      w = {w[30:0], bus.adc_sd};
      bus.adc_clk = 1'b0;
      repeat (half) @(negedge clk);
      bus.adc_clk = 1'b1;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic end_frame(input int half);
    bus.adc_cs = 1'b1;
    repeat (half + 4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    int b_un, b_done, b_ab;
    logic [31:0] exp_prev5;

    rst = 1'b1;
    bus.adc_cs = 1'b1;
    bus.adc_clk = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sd", bus.adc_sd, 0);
    check("rst_ready", bus.s_ready, 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_done", bus.frame_done, 0);
    check("rst_abort", bus.frame_abort, 0);
    check("rst_underrun", bus.underrun, 0);

    // reset in the middle of a frame, with a further sample held
    push(12'hC00);
    start_frame(HALF);
    push(12'h3A5);
    shift_bits(5, HALF, w);
    check("midrst_sd_before", bus.adc_sd, 1);
    rst = 1'b1;
    #1;
    check("midrst_sd", bus.adc_sd, 0);
    check("midrst_ready", bus.s_ready, 1);
    bus.adc_cs = 1'b1;
    bus.adc_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    b_un = n_un;
    start_frame(HALF); shift_bits(16, HALF, w); end_frame(HALF);
    check("postrst_word", w, 32'h0000);
    check("postrst_underrun", n_un - b_un, 1);
    b_done = n_done;
    push(12'h1E7);
    start_frame(HALF); shift_bits(16, HALF, w); end_frame(HALF);
    check("postrst_clean", w, 32'h01E7);
    check("postrst_done", n_done - b_done, 1);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    tbl[0] = '{1'b1, 12'hABC, 16, 32'h0ABC, 0, 1, 0};
    tbl[1] = '{1'b1, 12'h123, 16, 32'h0123, 0, 1, 0};
`ifdef ADC_RESP_TONE_EN
    tbl[2] = '{1'b0, 12'h000, 16, 32'h0000, 1, 1, 0};
`else
    tbl[2] = '{1'b0, 12'h000, 16, 32'h0123, 1, 1, 0};
`endif
    tbl[3] = '{1'b1, 12'h555, 7,  32'h0002, 0, 0, 1};
    tbl[4] = '{1'b1, 12'h3C3, 16, 32'h03C3, 0, 1, 0};
`ifdef ADC_RESP_TONE_EN
    tbl[5] = '{1'b0, 12'h000, 16, 32'h0040, 1, 1, 0};
`else
    tbl[5] = '{1'b0, 12'h000, 16, 32'h03C3, 1, 1, 0};
`endif
    tbl[6] = '{1'b1, 12'hFED, 18, 32'h3FB4, 0, 1, 0};

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].load) push(tbl[i].data);
      b_un = n_un; b_done = n_done; b_ab = n_abort;
      start_frame(HALF);
      shift_bits(tbl[i].falls, HALF, w);
      if (tbl[i].falls >= 16) check($sformatf("v%0d_tail_sd", i), bus.adc_sd, 0);
      end_frame(HALF);
      check($sformatf("v%0d_word", i), w, tbl[i].exp_word);
      check($sformatf("v%0d_underrun", i), n_un - b_un, tbl[i].exp_un);
      check($sformatf("v%0d_done", i), n_done - b_done, tbl[i].exp_done);
      check($sformatf("v%0d_abort", i), n_abort - b_ab, tbl[i].exp_abort);
      check($sformatf("v%0d_idle_sd", i), bus.adc_sd, 0);
    end

    // load lands in the same clk the cs fall is detected
`ifdef ADC_RESP_TONE_EN
    exp_prev5 = 32'h0080;
`else
    exp_prev5 = 32'h0FED;
`endif
    b_un = n_un;
    bus.adc_cs = 1'b0;
    repeat (2) @(negedge clk);
    bus.s_data = 12'h7FF;
    bus.s_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("same_clk_ready_low", bus.s_ready, 0);
    shift_bits(16, HALF, w);
    end_frame(HALF);
    check("same_clk_word", w, exp_prev5);
    check("same_clk_underrun", n_un - b_un, 1);
    check("same_clk_ready_between", bus.s_ready, 0);
    bus.s_valid = 1'b0;
    b_un = n_un;
    start_frame(HALF); shift_bits(16, HALF, w); end_frame(HALF);
    check("held_word", w, 32'h07FF);
    check("held_underrun", n_un - b_un, 0);
    check("held_ready_after", bus.s_ready, 1);

    // cs fall and adc_clk fall arrive together: the first bit must survive
    push(12'h8F1);
    bus.adc_cs = 1'b0;
    bus.adc_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.adc_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    shift_bits(16, HALF, w);
    end_frame(HALF);
    check("coincident_word", w, 32'h08F1);

    b_un = n_un;
    for (int v = 0; v < 100; v++) begin
      push(12'(v));
      start_frame(HALF); shift_bits(16, HALF, w); end_frame(HALF);
      check($sformatf("ramp_%0d", v), w, 32'(v));
    end
    check("ramp_underrun", n_un - b_un, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
